// File: rtl/skew_stream_buf.sv
// Double-buffered DIMxDIM operand tile buffer that streams the stored tile as DIM
// diagonally skewed lanes, row-major or transposed, while the other bank is refilled.
module skew_stream_buf #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [$clog2(DIM)-1:0] i_wr_row,
  input  logic [BITS_AB-1:0]     i_wr_data [DIM-1:0],
  input  logic                   i_start,
  input  logic                   i_transpose,
  input  logic                   i_en,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [BITS_AB-1:0]     o_aout [DIM-1:0],
  output logic [DIM-1:0]         o_aout_valid
);
  localparam int unsigned KW = $clog2(2 * DIM - 1);
  localparam int unsigned RW = $clog2(DIM);
  localparam logic [KW-1:0] KLast = KW'(2 * DIM - 2);

  typedef enum logic {StIdle, StStream} state_e;

  state_e             r_state, w_state_n;
  logic [BITS_AB-1:0] r_mem [2][DIM-1:0][DIM-1:0];
  logic               r_fb, r_tmode, r_done;
  logic [KW-1:0]      r_k;
  logic [BITS_AB-1:0] r_aout [DIM-1:0];
  logic [DIM-1:0]     r_valid;

  logic               w_accept, w_upd, w_beat, w_fb_n, w_tmode_n, w_sb, w_done_n;
  logic [KW-1:0]      w_k_n;
  logic [BITS_AB-1:0] w_aout_n [DIM-1:0];
  logic [DIM-1:0]     w_valid_n;
  int                 w_i;

  // r_k is the beat currently on the outputs; the next beat is computed and registered together.
  always_comb begin
    o_ready   = (r_state == StIdle) | ((r_k == KLast) & i_en);
    w_accept  = i_start & o_ready;
    w_state_n = r_state;
    w_k_n     = r_k;
    w_fb_n    = r_fb;
    w_tmode_n = r_tmode;
    w_upd     = 1'b0;
    w_beat    = 1'b0;
    if (w_accept) begin
      w_state_n = StStream;
      w_k_n     = '0;
      w_fb_n    = ~r_fb;
      w_tmode_n = i_transpose;
      w_upd     = 1'b1;
      w_beat    = 1'b1;
    end else if (i_en) begin
      w_upd = 1'b1;
      if ((r_state == StStream) && (r_k != KLast)) begin
        w_k_n  = r_k + 1'b1;
        w_beat = 1'b1;
      end else begin
        w_state_n = StIdle;
        w_k_n     = '0;
      end
    end
    w_sb     = ~w_fb_n;
    w_done_n = w_beat & (w_k_n == KLast);
    w_i      = 0;
    for (int r = 0; r < int'(DIM); r++) begin
      w_aout_n[r]  = '0;
      w_valid_n[r] = 1'b0;
      w_i          = int'(w_k_n) - r;
      if (w_beat && (w_i >= 0) && (w_i < int'(DIM))) begin
        w_valid_n[r] = 1'b1;
        w_aout_n[r]  = w_tmode_n ? r_mem[w_sb][w_i[RW-1:0]][r[RW-1:0]]
                                 : r_mem[w_sb][r[RW-1:0]][w_i[RW-1:0]];
      end
    end
    // Beat 0 only needs element (0,0); forward a row-0 write landing on the accept edge.
    if (w_accept && i_wr_en && (i_wr_row == '0)) begin
      w_aout_n[0] = i_wr_data[0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_k     <= '0;
      r_fb    <= 1'b0;
      r_tmode <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_k     <= w_k_n;
      r_fb    <= w_fb_n;
      r_tmode <= w_tmode_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done  <= 1'b0;
      r_valid <= '0;
      for (int r = 0; r < int'(DIM); r++) begin
        r_aout[r] <= '0;
      end
    end else if (w_upd) begin
      r_done  <= w_done_n;
      r_valid <= w_valid_n;
      r_aout  <= w_aout_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(DIM); i++) begin
          for (int j = 0; j < int'(DIM); j++) begin
            r_mem[b][i][j] <= '0;
          end
        end
      end
    end else if (i_wr_en) begin
      for (int j = 0; j < int'(DIM); j++) begin
        r_mem[r_fb][i_wr_row][j] <= i_wr_data[j];
      end
    end
  end

  assign o_busy       = (r_state == StStream);
  assign o_done       = r_done;
  assign o_aout       = r_aout;
  assign o_aout_valid = r_valid;

endmodule

// File: tb/tb_skew_stream_buf.sv
// Directed bench for skew_stream_buf (DIM=4): a bank model pushes the expected beats of a
// tile into a scoreboard on start accept; each advancing cycle pops and compares.
module tb_skew_stream_buf;
  localparam int DIM = 4;
  localparam int LAST = 2 * DIM - 2;

  logic           clk = 1'b0;
  logic           rst, wr_en, start, transpose, en;
  logic           ready, busy, done;
  logic [1:0]     wr_row;
  logic [7:0]     wr_data [DIM-1:0];
  logic [7:0]     aout [DIM-1:0];
  logic [DIM-1:0] aout_valid;

  always #5 clk = ~clk;

  skew_stream_buf #(.BITS_AB(8), .DIM(DIM)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_en     (wr_en),
    .i_wr_row    (wr_row),
    .i_wr_data   (wr_data),
    .i_start     (start),
    .i_transpose (transpose),
    .i_en        (en),
    .o_ready     (ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_aout      (aout),
    .o_aout_valid(aout_valid)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  valid;
    logic        dn;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      last;
  logic [7:0] mb [2][4][4];
  int         mfb;
  bit         m_busy;
  int         m_k;
  int         total = 0;
  int         bad = 0;
  string      cur = "init";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s_%s observed=%0h expected=%0h", cur, tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] packed_aout();
    return {aout[3], aout[2], aout[1], aout[0]};
  endfunction

  function automatic logic [31:0] row16(input int r);
    logic [31:0] v;
    for (int j = 0; j < DIM; j++) v[8*j +: 8] = 8'(16 * r + j);
    return v;
  endfunction

  function automatic void push_tile(input int bank, input bit tr);
    for (int k = 0; k <= LAST; k++) begin
      beat_t b;
      b = '0;
      b.dn = (k == LAST);
      for (int r = 0; r < DIM; r++) begin
        int i;
        i = k - r;
        if (i >= 0 && i < DIM) begin
          b.valid[r] = 1'b1;
          b.data[8*r +: 8] = tr ? mb[bank][i][r] : mb[bank][r][i];
        end
      end
      exp_q.push_back(b);
    end
  endfunction

  function automatic beat_t pop_exp();
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb_underflow observed=empty expected=beat", cur);
      return '0;
    end
    return exp_q.pop_front();
  endfunction

  task automatic check_out(input string tag, input beat_t e);
    chk({tag, "_data"}, 64'(packed_aout()), 64'(e.data));
    chk({tag, "_valid"}, 64'(aout_valid), 64'(e.valid));
    chk({tag, "_done"}, 64'(done), 64'(e.dn));
  endtask

  // One clock: drive inputs, check ready, step the model, then compare the registered beat.
  task automatic cycle(input bit st, input bit tr, input bit e, input bit wr, input int row,
                       input logic [31:0] rd);
    bit    rdy;
    beat_t ex;
    start = st; transpose = tr; en = e; wr_en = wr; wr_row = row[1:0];
    for (int j = 0; j < DIM; j++) wr_data[j] = rd[8*j +: 8];
    #1;
    rdy = !m_busy || (m_k == LAST && e);
    chk("ready", 64'(ready), 64'(rdy));
    if (wr) for (int j = 0; j < DIM; j++) mb[mfb][row][j] = rd[8*j +: 8];
    if (st && rdy) begin
      mfb = 1 - mfb;
      exp_q.delete();
      push_tile(1 - mfb, tr);
      m_busy = 1'b1;
      m_k = 0;
      ex = pop_exp();
    end else if (e) begin
      if (m_busy && m_k < LAST) begin
        m_k++;
        ex = pop_exp();
      end else begin
        m_busy = 1'b0;
        ex = '0;
      end
    end else begin
      ex = last;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
    check_out("beat", ex);
    chk("busy", 64'(busy), 64'(m_busy));
    last = ex;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) mb[b][i][j] = 8'h00;
    mfb = 0; m_busy = 1'b0; m_k = 0; last = '0;
    exp_q.delete();
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    check_out("rst", '0);
  endtask

  task automatic load_tile16();
    for (int r = 0; r < DIM; r++) cycle(0, 0, 1, 1, r, row16(r));
  endtask

  task automatic run_beats(input int n);
    for (int b = 0; b < n; b++) cycle(0, 0, 1, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_row = '0; start = 1'b0; transpose = 1'b0; en = 1'b1;
    for (int j = 0; j < DIM; j++) wr_data[j] = 8'h00;

    cur = "reset";
    do_reset();
    run_beats(1);

    // Row-major; row 0 is written on the accept edge itself.
    cur = "t1";
    for (int r = 1; r < DIM; r++) cycle(0, 0, 1, 1, r, row16(r));
    cycle(1, 0, 1, 1, 0, row16(0));
    for (int b = 1; b <= LAST; b++) begin
      cycle(0, 0, 1, 0, 0, 32'h0);
      if (b == 2) chk("lane2_b2", 64'(aout[2]), 64'h20);
      if (b == 5) chk("lane2_b5", 64'(aout[2]), 64'h23);
      if (b == 4) chk("lane0_b4_valid", 64'(aout_valid[0]), 64'h0);
    end
    chk("done_b6", 64'(done), 64'h1);
    run_beats(1);

    cur = "t2";
    load_tile16();
    cycle(1, 1, 1, 0, 0, 32'h0);
    for (int b = 1; b <= LAST; b++) begin
      cycle(0, 0, 1, 0, 0, 32'h0);
      if (b == 1) chk("lane1_b1", 64'(aout[1]), 64'h01);
      if (b == 4) chk("lane1_b4", 64'(aout[1]), 64'h31);
    end
    run_beats(1);

    // Ping-pong: refill the other bank with -1 while 0x11 streams, restart on the done beat.
    cur = "pp";
    for (int r = 1; r < DIM; r++) cycle(0, 0, 1, 1, r, 32'h11111111);
    cycle(1, 0, 1, 1, 0, 32'h11111111);
    chk("a_b0", 64'(aout[0]), 64'h11);
    for (int b = 1; b <= LAST; b++) begin
      if (b <= DIM) cycle(0, 0, 1, 1, b - 1, 32'hFFFFFFFF);
      else cycle(0, 0, 1, 0, 0, 32'h0);
    end
    chk("a_done", 64'(done), 64'h1);
    cycle(1, 0, 1, 0, 0, 32'h0);
    chk("b_first", 64'(aout[0]), 64'hFF);
    chk("b_first_valid", 64'(aout_valid), 64'h1);
    run_beats(LAST + 1);

    cur = "stall";
    cycle(1, 0, 1, 0, 0, 32'h0);
    run_beats(3);
    for (int s = 0; s < 3; s++) cycle(0, 0, 0, 0, 0, 32'h0);
    run_beats(3);
    chk("done_b6", 64'(done), 64'h1);
    cycle(0, 0, 0, 0, 0, 32'h0);
    chk("done_held", 64'(done), 64'h1);
    run_beats(1);

    cur = "ign";
    cycle(1, 0, 1, 0, 0, 32'h0);
    run_beats(2);
    cycle(1, 1, 1, 0, 0, 32'h0);
    run_beats(LAST - 3);
    chk("done_b6", 64'(done), 64'h1);
    run_beats(1);

    cur = "rst";
    load_tile16();
    cycle(1, 0, 1, 0, 0, 32'h0);
    run_beats(3);
    do_reset();
    run_beats(1);
    chk("no_done", 64'(done), 64'h0);
    cycle(1, 0, 1, 0, 0, 32'h0);
    run_beats(LAST);
    chk("zero_lane3_valid", 64'(aout_valid[3]), 64'h1);
    run_beats(1);

    cur = "end";
    chk("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
